rom_port_arbiter: RTL and testbench
===================================

Name: rom_port_arbiter

Overview:
- Shares the single combinational, byte-addressed, 32-bit instruction ROM between two read requesters: the CPU instruction-fetch port (IF) and the debug/monitor read port (DBG).
- Sits between the fetch stage, the debug monitor and the ROM instance.
- Fixed priority to IF with an aging override, so DBG cannot starve.
- Captures the word into per-port registered read data with a req/gnt/rvalid handshake.

Parameters:
- ROM_BYTES, 128, ROM size in bytes; valid word addresses are 0 .. ROM_BYTES-4.
- STARVE_LIMIT, 4, consecutive cycles DBG may wait before it wins priority (1..15).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held high with stable if_addr until if_gnt
- if_addr  in  32  fetch byte address
- if_gnt  out  1  combinational grant, same cycle as accepted request
- if_rvalid  out  1  one-cycle pulse, cycle after if_gnt
- if_rdata  out  32  fetched word, valid with if_rvalid, held until next if_rvalid
- if_err  out  1  with if_rvalid: access was misaligned or out of range
- dbg_req, dbg_addr, dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err: same directions, widths and meaning for the DBG port
- rom_addr  out  32  address driven to ROM
- rom_data  in  32  ROM instruction output (combinational from rom_addr)

Behaviour:
- Reset (async, immediate): all rvalid/err = 0; rdata = 0; rom_addr = 0; wait counter = 0; state = IF_PRIO. Gnts are 0 while rst is high.
- Throughput: at most one grant per cycle; each port has at most one request in flight. Read latency is 1 cycle (gnt in cycle N, rvalid in N+1).
- Grant cycle: rom_addr = granted port's address, combinationally. rom_data is sampled at the clock edge into that port's rdata.
- Idle cycle: rom_addr holds the last granted address.
- Address check:
  - misaligned = addr[1:0] != 0; out of range = addr > ROM_BYTES-4 (32-bit unsigned compare).
  - Either condition: request is still granted, the ROM is not driven with the bad address (rom_addr holds), rdata loads 0, err = 1 with rvalid.
- FSM, 2 states:
  - IF_PRIO: if_req wins whenever asserted; DBG is granted only when if_req = 0. Go to DBG_AGED when wait counter reaches STARVE_LIMIT while dbg_req is pending.
  - DBG_AGED: DBG is granted unconditionally this cycle and IF is stalled (if_gnt = 0). Next state is IF_PRIO.
- Wait counter (4 bits):
  - increments each cycle dbg_req = 1 and dbg_gnt = 0;
  - clears on dbg_gnt or when dbg_req = 0;
  - saturates at 15.
- Simultaneous requests in IF_PRIO below the limit: IF granted, DBG waits, counter increments.
- Request dropped before grant (protocol violation): no grant, no rvalid, counter clears. Never lock up.
- Reset asserted mid-transfer: the pending rvalid is discarded; no rvalid after reset release until a new grant.

Optional Feature:
- Macro: ROM_ARB_STATS_EN.
- Defined:
  - adds output conflict_cnt (16 bits), reset 0;
  - increments every cycle both if_req and dbg_req are high;
  - saturates at 16'hFFFF.
  - Also adds output aged_cnt (8 bits, saturating), counting DBG_AGED grants.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Standard program image, if_req = 1 at addr 0x00, then 0x0C: if_gnt the same cycle each time. if_rvalid in the next cycle with if_rdata 0x8C040000, then 0x0C000006; if_err = 0; dbg outputs stay 0.
- dbg_req = 1 at 0x58 while if_req is continuously high (addr 0x04, 0x08, ...), STARVE_LIMIT = 4:
  - IF is granted 4 cycles, then cycle 5 gives dbg_gnt = 1 and if_gnt = 0;
  - next cycle dbg_rvalid = 1, dbg_rdata = 0x03E00008; IF resumes the following cycle.
- Only dbg_req = 1 at 0x10: granted immediately; dbg_rdata = 0xAC02000C; wait counter stays 0.
- if_req at 0x06 (misaligned), then 0x80 (ROM_BYTES = 128): each granted; rvalid with rdata = 0 and if_err = 1; rom_addr unchanged.
- Assert rst in the cycle after if_gnt: if_rvalid never pulses. After release, all outputs are 0 and state is IF_PRIO (a new DBG waits a full STARVE_LIMIT under IF pressure).
- With ROM_ARB_STATS_EN, both ports requesting for 10 cycles: conflict_cnt = 10, aged_cnt = 2. Preload near max: conflict_cnt holds at 0xFFFF.

Source files
------------

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares one combinational 32-bit instruction ROM between the fetch (IF) and debug (DBG) read ports.
// Optional statistics outputs (conflict_cnt, aged_cnt) are built when ROM_ARB_STATS_EN is defined.
//
//   state    | meaning
//   IF_PRIO  | IF wins whenever it requests; DBG only gets idle cycles
//   DBG_AGED | DBG waited STARVE_LIMIT cycles; DBG granted, IF stalled for one cycle
module rom_port_arbiter #(
    parameter int unsigned ROM_BYTES    = 128,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        dbg_req,
    input  logic [31:0] dbg_addr,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic [31:0] dbg_rdata,
    output logic        dbg_err,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data
`ifdef ROM_ARB_STATS_EN
    ,
    output logic [15:0] conflict_cnt,
    output logic [7:0]  aged_cnt
`endif
);

    localparam logic [31:0] LAST_WORD = 32'(ROM_BYTES - 4);
    localparam logic [3:0]  LIMIT     = 4'(STARVE_LIMIT);

    typedef enum logic {
        IF_PRIO  = 1'b0,
        DBG_AGED = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_wait_cnt;
    logic [3:0]  w_wait_next;
    logic [31:0] r_rom_addr;
    logic [31:0] w_rom_addr;
    logic        w_if_gnt;
    logic        w_dbg_gnt;
    logic        w_if_bad;
    logic        w_dbg_bad;

    logic        r_if_rvalid;
    logic [31:0] r_if_rdata;
    logic        r_if_err;
    logic        r_dbg_rvalid;
    logic [31:0] r_dbg_rdata;
    logic        r_dbg_err;

    assign w_if_bad  = (if_addr[1:0] != 2'b00) || (if_addr > LAST_WORD);
    assign w_dbg_bad = (dbg_addr[1:0] != 2'b00) || (dbg_addr > LAST_WORD);

    always_comb begin
        w_if_gnt     = 1'b0;
        w_dbg_gnt    = 1'b0;
        w_wait_next  = 4'd0;
        w_state_next = IF_PRIO;
        if (!rst) begin
            case (r_state)
                DBG_AGED: w_dbg_gnt = dbg_req;
                default: begin
                    w_if_gnt  = if_req;
                    w_dbg_gnt = dbg_req && !if_req;
                end
            endcase
        end
        if (dbg_req && !w_dbg_gnt) begin
            w_wait_next = (r_wait_cnt == 4'hF) ? 4'hF : r_wait_cnt + 4'd1;
        end
        // Aging decision uses the post-increment count so DBG wins exactly STARVE_LIMIT cycles after it started waiting.
        if ((r_state == IF_PRIO) && dbg_req && !w_dbg_gnt && (w_wait_next >= LIMIT)) begin
            w_state_next = DBG_AGED;
        end
    end

    // Bad addresses never reach the ROM; the bus keeps the last good address.
    always_comb begin
        w_rom_addr = r_rom_addr;
        if (w_if_gnt && !w_if_bad) begin
            w_rom_addr = if_addr;
        end else if (w_dbg_gnt && !w_dbg_bad) begin
            w_rom_addr = dbg_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IF_PRIO;
            r_wait_cnt   <= 4'd0;
            r_rom_addr   <= 32'd0;
            r_if_rvalid  <= 1'b0;
            r_if_rdata   <= 32'd0;
            r_if_err     <= 1'b0;
            r_dbg_rvalid <= 1'b0;
            r_dbg_rdata  <= 32'd0;
            r_dbg_err    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_wait_cnt   <= w_wait_next;
            r_rom_addr   <= w_rom_addr;
            r_if_rvalid  <= w_if_gnt;
            r_if_err     <= w_if_gnt && w_if_bad;
            r_dbg_rvalid <= w_dbg_gnt;
            r_dbg_err    <= w_dbg_gnt && w_dbg_bad;
            if (w_if_gnt) begin
                r_if_rdata <= w_if_bad ? 32'd0 : rom_data;
            end
            if (w_dbg_gnt) begin
                r_dbg_rdata <= w_dbg_bad ? 32'd0 : rom_data;
            end
        end
    end

    assign if_gnt     = w_if_gnt;
    assign dbg_gnt    = w_dbg_gnt;
    assign rom_addr   = w_rom_addr;
    assign if_rvalid  = r_if_rvalid;
    assign if_rdata   = r_if_rdata;
    assign if_err     = r_if_err;
    assign dbg_rvalid = r_dbg_rvalid;
    assign dbg_rdata  = r_dbg_rdata;
    assign dbg_err    = r_dbg_err;

`ifdef ROM_ARB_STATS_EN
    logic [15:0] r_conflict_cnt;
    logic [7:0]  r_aged_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_conflict_cnt <= 16'd0;
            r_aged_cnt     <= 8'd0;
        end else begin
            if (if_req && dbg_req && (r_conflict_cnt != 16'hFFFF)) begin
                r_conflict_cnt <= r_conflict_cnt + 16'd1;
            end
            if ((r_state == DBG_AGED) && w_dbg_gnt && (r_aged_cnt != 8'hFF)) begin
                r_aged_cnt <= r_aged_cnt + 8'd1;
            end
        end
    end

    assign conflict_cnt = r_conflict_cnt;
    assign aged_cnt     = r_aged_cnt;
`endif

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Testbench for rom_port_arbiter: directed program-image scenarios plus random traffic against a queue scoreboard.
// Statistics checks are compiled in when ROM_ARB_STATS_EN is defined.
module tb_rom_port_arbiter;

    localparam int ROM_BYTES    = 128;
    localparam int STARVE_LIMIT = 4;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        dbg_req;
    logic [31:0] dbg_addr;
    logic        dbg_gnt;
    logic        dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        dbg_err;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
`ifdef ROM_ARB_STATS_EN
    logic [15:0] conflict_cnt;
    logic [7:0]  aged_cnt;
`endif

    logic [31:0] rom [32];
    resp_t       q_if[$];
    resp_t       q_dbg[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    // reference model state
    int          m_wait;
    bit          m_aged;
    logic [31:0] m_last;

    always #5 clk = ~clk;

    assign rom_data = (rom_addr <= 32'(ROM_BYTES - 4)) ? rom[rom_addr[6:2]] : 32'hDEADBEEF;

    rom_port_arbiter #(.ROM_BYTES(ROM_BYTES), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
        .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
        .rom_addr(rom_addr), .rom_data(rom_data)
`ifdef ROM_ARB_STATS_EN
        , .conflict_cnt(conflict_cnt), .aged_cnt(aged_cnt)
`endif
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit addr_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a > 32'(ROM_BYTES - 4));
    endfunction

    function automatic resp_t model_resp(input logic [31:0] a);
        resp_t r;
        if (addr_bad(a)) begin
            r.data = 32'd0;
            r.err  = 1'b1;
        end else begin
            r.data = rom[int'(a / 4)];
            r.err  = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            8:       return 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
            9: begin
                case ($urandom_range(0, 2))
                    0:       return 32'd128;
                    1:       return 32'hFFFF_FFFC;
                    default: return 32'(128 + $urandom_range(0, 1000) * 4);
                endcase
            end
            default: return 32'($urandom_range(0, 31) * 4);
        endcase
    endfunction

    // One arbitration cycle: drive at negedge, compare grants and rom_addr with the model, queue the expected response.
    task automatic step(input logic ir, input logic [31:0] ia, input logic dr, input logic [31:0] da,
                        output logic gi, output logic gd);
        logic egi, egd;
        @(negedge clk);
        if_req   = ir;
        if_addr  = ia;
        dbg_req  = dr;
        dbg_addr = da;
        #1;
        if (m_aged) begin
            egi    = 1'b0;
            egd    = dr;
            m_aged = 1'b0;
        end else if (ir) begin
            egi = 1'b1;
            egd = 1'b0;
        end else begin
            egi = 1'b0;
            egd = dr;
        end
        check("if_gnt", 32'(if_gnt), 32'(egi));
        check("dbg_gnt", 32'(dbg_gnt), 32'(egd));
        if (egi) begin
            q_if.push_back(model_resp(ia));
            if (!addr_bad(ia)) m_last = ia;
        end else if (egd) begin
            q_dbg.push_back(model_resp(da));
            if (!addr_bad(da)) m_last = da;
        end
        check("rom_addr", rom_addr, m_last);
        if (dr && !egd) begin
            m_wait = (m_wait < 15) ? m_wait + 1 : 15;
            if (m_wait >= STARVE_LIMIT) m_aged = 1'b1;
        end else begin
            m_wait = 0;
        end
        gi = egi;
        gd = egd;
    endtask

    task automatic apply_reset(input int cycles);
        rst      = 1'b1;
        if_req   = 1'b0;
        dbg_req  = 1'b0;
        q_if.delete();
        q_dbg.delete();
        m_wait = 0;
        m_aged = 1'b0;
        m_last = 32'd0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            check("rst_if_rvalid", 32'(if_rvalid), 32'd0);
            check("rst_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_if_gnt"}, 32'(if_gnt), 32'd0);
        check({nm, "_dbg_gnt"}, 32'(dbg_gnt), 32'd0);
        check({nm, "_if_rvalid"}, 32'(if_rvalid), 32'd0);
        check({nm, "_dbg_rvalid"}, 32'(dbg_rvalid), 32'd0);
        check({nm, "_if_rdata"}, if_rdata, 32'd0);
        check({nm, "_dbg_rdata"}, dbg_rdata, 32'd0);
        check({nm, "_if_err"}, 32'(if_err), 32'd0);
        check({nm, "_dbg_err"}, 32'(dbg_err), 32'd0);
        check({nm, "_rom_addr"}, rom_addr, 32'd0);
    endtask

    // IF hammers the port while DBG waits; returns how many IF grants preceded the DBG grant.
    task automatic aging_run(input logic [31:0] dbg_a, inout logic [31:0] ia, output int n_if, output bit got);
        logic gi, gd;
        n_if = 0;
        got  = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            step(1'b1, ia, 1'b1, dbg_a, gi, gd);
            if (gi) begin
                n_if++;
                ia = ia + 32'd4;
            end
            if (gd) got = 1'b1;
        end
    endtask

    // Monitor: pops the scoreboard whenever a port presents rvalid.
    always @(posedge clk) begin
        resp_t r;
        #1;
        if (!rst) begin
            if (if_rvalid) begin
                if (q_if.size() == 0) begin
                    check("if_rvalid_unexpected", 32'(if_rvalid), 32'd0);
                end else begin
                    r = q_if.pop_front();
                    check("if_rdata", if_rdata, r.data);
                    check("if_err", 32'(if_err), 32'(r.err));
                end
            end
            if (dbg_rvalid) begin
                if (q_dbg.size() == 0) begin
                    check("dbg_rvalid_unexpected", 32'(dbg_rvalid), 32'd0);
                end else begin
                    r = q_dbg.pop_front();
                    check("dbg_rdata", dbg_rdata, r.data);
                    check("dbg_err", 32'(dbg_err), 32'(r.err));
                end
            end
            if (q_if.size() != 0) begin
                check("if_rvalid_missing", 32'(if_rvalid), 32'd1);
                q_if.delete();
            end
            if (q_dbg.size() != 0) begin
                check("dbg_rvalid_missing", 32'(dbg_rvalid), 32'd1);
                q_dbg.delete();
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        gi, gd, pi, pd;
        logic [31:0] ia, ai, ad;
        int          n_if;
        bit          got;

        for (int i = 0; i < 32; i++) rom[i] = 32'h5A00_0000 ^ 32'(i * 32'h0001_0203);
        rom[0]  = 32'h8C04_0000;
        rom[3]  = 32'h0C00_0006;
        rom[4]  = 32'hAC02_000C;
        rom[22] = 32'h03E0_0008;

        // reset: grants held off even with a request pending
        rst      = 1'b1;
        if_req   = 1'b1;
        if_addr  = 32'h0;
        dbg_req  = 1'b1;
        dbg_addr = 32'h10;
        #2;
        check_all_zero("reset");
        apply_reset(2);

        // standard program fetches
        step(1'b1, 32'h00, 1'b0, 32'h0, gi, gd);
        @(posedge clk);
        #1;
        check("fetch0_rvalid", 32'(if_rvalid), 32'd1);
        check("fetch0_rdata", if_rdata, 32'h8C04_0000);
        check("fetch0_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
        step(1'b1, 32'h0C, 1'b0, 32'h0, gi, gd);
        @(posedge clk);
        #1;
        check("fetch1_rdata", if_rdata, 32'h0C00_0006);
        check("fetch1_err", 32'(if_err), 32'd0);
        check("fetch1_dbg_rdata", dbg_rdata, 32'd0);

        // aging: DBG at 0x58 under continuous IF pressure
        ia = 32'h04;
        aging_run(32'h58, ia, n_if, got);
        check("aged_if_grants", 32'(n_if), 32'(STARVE_LIMIT));
        check("aged_dbg_gnt", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        check("aged_dbg_rvalid", 32'(dbg_rvalid), 32'd1);
        check("aged_dbg_rdata", dbg_rdata, 32'h03E0_0008);
        step(1'b1, ia, 1'b0, 32'h0, gi, gd);
        check("if_resume", 32'(gi), 32'd1);

        // DBG alone
        step(1'b0, 32'h0, 1'b1, 32'h10, gi, gd);
        check("dbg_only_gnt", 32'(gd), 32'd1);
        @(posedge clk);
        #1;
        check("dbg_only_rdata", dbg_rdata, 32'hAC02_000C);

        // misaligned then out of range
        step(1'b1, 32'h06, 1'b0, 32'h0, gi, gd);
        check("misaligned_rom_addr", rom_addr, 32'h10);
        @(posedge clk);
        #1;
        check("misaligned_err", 32'(if_err), 32'd1);
        check("misaligned_rdata", if_rdata, 32'd0);
        step(1'b1, 32'h80, 1'b0, 32'h0, gi, gd);
        check("range_rom_addr", rom_addr, 32'h10);
        @(posedge clk);
        #1;
        check("range_err", 32'(if_err), 32'd1);

        // reset while a grant is outstanding
        step(1'b1, 32'h20, 1'b0, 32'h0, gi, gd);
        apply_reset(2);
        #1;
        check_all_zero("post_reset");
        @(posedge clk);
        #1;
        check("post_reset_if_rvalid", 32'(if_rvalid), 32'd0);
        ia = 32'h00;
        aging_run(32'h58, ia, n_if, got);
        check("post_reset_aged_if_grants", 32'(n_if), 32'(STARVE_LIMIT));

`ifdef ROM_ARB_STATS_EN
        apply_reset(1);
        pi = 1'b0;
        pd = 1'b0;
        ai = 32'h0;
        ad = 32'h40;
        for (int c = 0; c < 10; c++) begin
            step(1'b1, ai, 1'b1, ad, gi, gd);
            if (gi) ai = ai + 32'd4;
        end
        @(posedge clk);
        #1;
        check("conflict_cnt", 32'(conflict_cnt), 32'd10);
        check("aged_cnt", 32'(aged_cnt), 32'd2);
`endif

        // random traffic, including occasional request drops
        apply_reset(1);
        pi = 1'b0;
        pd = 1'b0;
        ai = 32'h0;
        ad = 32'h0;
        for (int c = 0; c < 800; c++) begin
            if (!pi && $urandom_range(0, 3) != 0) begin
                pi = 1'b1;
                ai = rand_addr();
            end
            if (!pd && $urandom_range(0, 2) == 0) begin
                pd = 1'b1;
                ad = rand_addr();
            end
            if (pi && $urandom_range(0, 49) == 0) pi = 1'b0;
            if (pd && $urandom_range(0, 49) == 0) pd = 1'b0;
            step(pi, ai, pd, ad, gi, gd);
            if (gi) pi = 1'b0;
            if (gd) pd = 1'b0;
        end
        step(1'b0, 32'h0, 1'b0, 32'h0, gi, gd);
        step(1'b0, 32'h0, 1'b0, 32'h0, gi, gd);
        check("final_if_queue", 32'(q_if.size()), 32'd0);
        check("final_dbg_queue", 32'(q_dbg.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
